// File: rtl/bus_inv_pkg.sv
// Shared types and helpers for the bus-invert receive path.
package bus_inv_pkg;

    localparam int unsigned BUS_INV_DEFAULT_WIDTH = 2;
    localparam int unsigned BUS_INV_MAX_WIDTH     = 64;

    // One lane group as seen on the wires: payload plus the shared INV flag.
    typedef struct packed {
        logic [BUS_INV_DEFAULT_WIDTH-1:0] data;
        logic                             inv;
    } bus_inv_word_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Number of set bits; callers zero-extend narrower words.
    function automatic int unsigned popcount(input logic [BUS_INV_MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < BUS_INV_MAX_WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_invert_decoder_if.sv
// Valid/ready word channel; the same interface type carries the wire side and the decoded side.
interface bus_inv_if
    import bus_inv_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_INV_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] data;
    logic             inv;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output inv,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  inv,
        input  valid,
        output ready
    );

endinterface

// File: rtl/bus_inv_skid_fifo.sv
// Two-entry registered buffer between the decoder and its consumer; head entry drives the output.
module bus_inv_skid_fifo
    import bus_inv_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_INV_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i
);

    fifo_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Handshake flags are derived from registered occupancy only, so no IN->OUT path exists.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        push    = wr_valid_i && ready_q;
        pop     = valid_q && rd_ready_i;

        unique case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    head_d  = wr_data_i;
                    state_d = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    head_d = wr_data_i;
                end else if (push) begin
                    skid_d  = wr_data_i;
                    state_d = FIFO_FULL;
                end else if (pop) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = FIFO_ONE;
                end
            end
            default: begin
                state_d = FIFO_EMPTY;
            end
        endcase

        valid_d = (state_d != FIFO_EMPTY);
        ready_d = (state_d != FIFO_FULL);
    end

    assign wr_ready_o = ready_q;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = head_q;

endmodule

// File: rtl/bus_invert_decoder.sv
// Restores polarity of bus-invert-coded words, buffers them, and audits the transmitter's invert decisions.
module bus_invert_decoder
    import bus_inv_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_INV_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bus_inv_if.slave         in_if,
    bus_inv_if.master        out_if,
    output logic             proto_err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] inv_cnt_o
);

    localparam int unsigned      POP_W   = $clog2(WIDTH) + 1;
    localparam int unsigned      HALF_W  = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] raw;
    logic [POP_W-1:0] toggles;
    logic             rule_ok;
    logic             accept;
    logic             fifo_ready;

    logic [WIDTH-1:0] prev_bus_q, prev_bus_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;

    assign raw     = in_if.data ^ {WIDTH{in_if.inv}};
    assign toggles = POP_W'(popcount(BUS_INV_MAX_WIDTH'(raw ^ prev_bus_q)));
    // Inverting is only legal when sending raw would toggle more than half the lanes.
    assign rule_ok = (in_if.inv == (toggles > POP_W'(HALF_W)));
    assign accept  = in_if.valid && fifo_ready;

    bus_inv_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .wr_data_i  (raw),
        .wr_valid_i (in_if.valid),
        .wr_ready_o (fifo_ready),
        .rd_data_o  (out_if.data),
        .rd_valid_o (out_if.valid),
        .rd_ready_i (out_if.ready)
    );

    assign in_if.ready = fifo_ready;
    assign out_if.inv  = 1'b0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_bus_q  <= '0;
            proto_err_q <= 1'b0;
            err_cnt_q   <= '0;
            inv_cnt_q   <= '0;
        end else begin
            prev_bus_q  <= prev_bus_d;
            proto_err_q <= proto_err_d;
            err_cnt_q   <= err_cnt_d;
            inv_cnt_q   <= inv_cnt_d;
        end
    end

    // Illegal words are still delivered; they only raise the pulse and bump the counter.
    always_comb begin
        prev_bus_d  = prev_bus_q;
        proto_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        inv_cnt_d   = inv_cnt_q;

        if (accept) begin
            prev_bus_d = in_if.data;
            if (!rule_ok) begin
                proto_err_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            if (in_if.inv && (inv_cnt_q != CNT_MAX)) begin
                inv_cnt_d = inv_cnt_q + CNT_W'(1);
            end
        end
    end

    assign proto_err_o = proto_err_q;
    assign err_cnt_o   = err_cnt_q;
    assign inv_cnt_o   = inv_cnt_q;

endmodule

// File: tb/tb_bus_invert_decoder.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal spot checks.
module tb_bus_invert_decoder;
    import bus_inv_pkg::*;

    localparam int unsigned W    = 2;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_inv_if #(.WIDTH(W)) in_if ();
    bus_inv_if #(.WIDTH(W)) out_if ();

    logic          proto_err;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] inv_cnt;

    bus_invert_decoder #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_if       (in_if),
        .out_if      (out_if),
        .proto_err_o (proto_err),
        .err_cnt_o   (err_cnt),
        .inv_cnt_o   (inv_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_prev = '0;
    int           m_err  = 0;
    int           m_inv  = 0;
    bit           m_perr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic i);
        in_if.valid = v;
        in_if.data  = d;
        in_if.inv   = i;
    endtask

    // Apply what the rising edge must do, from the transfer rules alone.
    task automatic model_edge();
        bit           do_pop, do_push, illegal;
        logic [W-1:0] r;
        int           h;
        if (rst) begin
            exp_q.delete();
            m_prev = '0;
            m_err  = 0;
            m_inv  = 0;
            m_perr = 1'b0;
        end else begin
            do_pop  = (exp_q.size() > 0) && (out_if.ready === 1'b1);
            do_push = (in_if.valid === 1'b1) && (exp_q.size() < 2);
            m_perr  = 1'b0;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                r       = in_if.data ^ {W{in_if.inv}};
                h       = $countones(r ^ m_prev);
                illegal = (in_if.inv != (h > int'(W / 2)));
                exp_q.push_back(r);
                m_prev = in_if.data;
                if (illegal) begin
                    m_perr = 1'b1;
                    if (m_err < CMAX) m_err++;
                end
                if (in_if.inv && m_inv < CMAX) m_inv++;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_if.ready), 32'(exp_q.size() < 2));
        chk("out_valid", 32'(out_if.valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("out_data", 32'(out_if.data), 32'(exp_q[0]));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("inv_cnt", 32'(inv_cnt), 32'(m_inv));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        bus_inv_word_t w;
        logic [W-1:0]  r;
        int            sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        rst          = 1'b1;
        out_if.ready = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2;

        // Reset held two cycles
        cycle();
        cycle();
        chk("rst_ready", 32'(in_if.ready), 32'd1);
        chk("rst_valid", 32'(out_if.valid), 32'd0);
        chk("rst_data", 32'(out_if.data), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_inv", 32'(inv_cnt), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);

        // Legal inverted word: 00/INV=1 decodes to 11
        rst = 1'b0;
        drive(1'b1, 2'b00, 1'b1);
        cycle();
        chk("dec_data", 32'(out_if.data), 32'h3);
        chk("dec_valid", 32'(out_if.valid), 32'd1);
        chk("dec_perr", 32'(proto_err), 32'd0);
        chk("dec_inv", 32'(inv_cnt), 32'd1);
        drive(1'b0, '0, 1'b0);
        out_if.ready = 1'b1;
        cycle();

        // Violation: 11 sent uninverted from PREV_BUS=00
        drive(1'b1, 2'b11, 1'b0);
        cycle();
        chk("viol_perr", 32'(proto_err), 32'd1);
        chk("viol_err", 32'(err_cnt), 32'd1);
        chk("viol_data", 32'(out_if.data), 32'h3);
        drive(1'b0, '0, 1'b0);
        cycle();
        chk("viol_pulse_end", 32'(proto_err), 32'd0);

        // Backpressure: 01,10 accepted, 11 stalls until release
        out_if.ready = 1'b0;
        drive(1'b1, 2'b01, 1'b0);
        cycle();
        drive(1'b1, 2'b10, 1'b0);
        cycle();
        chk("bp_full_ready", 32'(in_if.ready), 32'd0);
        drive(1'b1, 2'b11, 1'b0);
        repeat (3) cycle();
        chk("bp_stall_ready", 32'(in_if.ready), 32'd0);
        chk("bp_stall_data", 32'(out_if.data), 32'h1);
        out_if.ready = 1'b1;
        cycle();
        chk("bp_order2", 32'(out_if.data), 32'h2);
        chk("bp_ready_back", 32'(in_if.ready), 32'd1);
        cycle();
        chk("bp_order3", 32'(out_if.data), 32'h3);
        drive(1'b0, '0, 1'b0);
        cycle();
        chk("bp_drained", 32'(out_if.valid), 32'd0);

        // Streaming: 8 back-to-back words
        for (int k = 0; k < 8; k++) begin
            w.data = W'($urandom);
            w.inv  = 1'($urandom);
            drive(1'b1, w.data, w.inv);
            cycle();
            r = w.data ^ {W{w.inv}};
            chk("stream_valid", 32'(out_if.valid), 32'd1);
            chk("stream_data", 32'(out_if.data), 32'(r));
        end
        drive(1'b0, '0, 1'b0);
        cycle();

        // Reset with two words buffered
        out_if.ready = 1'b0;
        drive(1'b1, 2'b01, 1'b0);
        cycle();
        cycle();
        chk("mid_full", 32'(in_if.ready), 32'd0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        cycle();
        chk("mid_rst_valid", 32'(out_if.valid), 32'd0);
        chk("mid_rst_ready", 32'(in_if.ready), 32'd1);
        rst          = 1'b0;
        out_if.ready = 1'b1;
        cycle();
        chk("mid_dropped", 32'(out_if.valid), 32'd0);

        // Saturation: five illegal words alternating 11/00 uninverted
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, (k % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
            cycle();
            chk("sat_err", 32'(err_cnt), 32'(sat_exp[k]));
        end
        drive(1'b0, '0, 1'b0);
        cycle();

        // Randomised traffic, mostly rule-abiding, with occasional resets
        for (int k = 0; k < 3000; k++) begin
            logic inv;
            rst          = ($urandom_range(0, 199) == 0);
            out_if.ready = ($urandom_range(0, 3) != 0);
            r            = W'($urandom);
            inv          = ($countones(r ^ m_prev) > int'(W / 2));
            if ($urandom_range(0, 3) == 0) inv = ~inv;
            drive(1'($urandom), r ^ {W{inv}}, inv);
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
